sprite_anim_renderer: RTL and testbench
=======================================

// Module: sprite_anim_renderer
// PURPOSE
//  Draws one animated, positioned, integer-scaled sprite over a background colour on the VGA
//  pixel stream; successor to the full-screen single-image sprite drawer. Frames live
//  back-to-back in an external sync ROM (palette indices); an external combinational palette maps
//  index -> RGB. Adds position, 2^n scaling, colour-key transparency, a play/stop/one-shot frame
//  sequencer and a fixed pipeline aligned to DrawX/DrawY.
// PARAMETERS
//  SPR_W       100  sprite width in texels
//  SPR_H       100  sprite height in texels
//  FRAMES      4    animation frames stored in ROM, frame f at base f*SPR_W*SPR_H
//  IDX_W       4    palette index width
//  SCALE_SHIFT 0    each texel drawn as (1<<SCALE_SHIFT)^2 pixels, 0..3
//  FRAME_TICKS 8    video frames each animation frame is held, >=1
//  TRANSP_IDX  0    rom index treated as transparent
//  ADDR_W      $clog2(FRAMES*SPR_W*SPR_H)  rom address width (derived)
// PORTS
//  vga_clk      in  1      pixel clock, all logic on posedge
//  reset_n      in  1      async active-low reset
//  DrawX,DrawY  in  10     current pixel coordinates
//  blank        in  1      1 = active video
//  vs           in  1      vsync, active low; falling edge = frame boundary
//  sprite_x/_y  in  10     sprite top-left, sampled only at frame boundary
//  start        in  1      1-cycle pulse: (re)start animation at frame 0
//  stop         in  1      1-cycle pulse: stop, return to frame 0
//  one_shot     in  1      1 = stop on last frame (DONE), 0 = loop
//  bg_red/green/blue in 4  background colour
//  rom_address  out ADDR_W registered ROM address
//  rom_q        in  IDX_W  ROM data, valid one cycle after rom_address
//  pal_index    out IDX_W  = registered rom_q path, to palette
//  pal_red/green/blue in 4 palette colour for pal_index (combinational)
//  red,green,blue out 4    pixel colour, registered
//  anim_frame   out $clog2(FRAMES) current frame;  anim_done out 1  high in DONE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, frame 0, tick count 0, latched pos 0, pipeline hit/blank 0.
//  Frame boundary fb: vs_q==1 && vs==0 (vs registered one cycle). On fb: pos_x/pos_y <= sprite_x/_y.
//  Pipeline (latency 2): edge k samples DrawX/DrawY/blank -> s1 {rom_address, hit1, blank1};
//   ROM returns rom_q after edge k+1 -> s2 {hit2, blank2}; edge k+2 writes red/green/blue.
//  Hit: dx=DrawX-pos_x, dy=DrawY-pos_y computed 11-bit unsigned after pos<=Draw check;
//   hit = DrawX>=pos_x && dx<(SPR_W<<S) && DrawY>=pos_y && dy<(SPR_H<<S). No wrap: parts
//   beyond 639/479 are simply never drawn. rom_address = frame*SPR_W*SPR_H + (dy>>S)*SPR_W
//   + (dx>>S) when hit, else 0.
//  Output at edge k+2: blank2==0 -> 0; hit2 && rom_q!=TRANSP_IDX -> pal_*; else bg_*.
//  Sequencer states IDLE, PLAY, DONE; tick counter 0..FRAME_TICKS-1.
//   IDLE: frame 0; start -> PLAY, tick 0.  PLAY: on fb, tick++; at tick==FRAME_TICKS-1 tick<=0
//   and frame advances; from FRAMES-1: one_shot ? DONE (hold last frame) : frame 0.
//   DONE: anim_done=1; start -> PLAY from frame 0.  stop in any state -> IDLE, frame 0, tick 0.
//   start && stop same cycle: stop wins. start in PLAY restarts at frame 0, tick 0.
//  frame/pos change only at fb, so no tearing inside a frame. FRAMES==1: PLAY holds frame 0
//   (one_shot -> DONE after FRAME_TICKS frames).
//  reset_n low mid-frame: outputs 0 immediately (async), pipeline refills within 2 cycles.
// TESTING
//  Reset: reset_n=0 mid-line -> red/green/blue=0, anim_frame=0, anim_done=0 at once.
//  Position: sprite at (200,100), S=0, fb; DrawX=200,DrawY=100 -> rom_address=0,
//   colour=pal_* 2 cycles later; DrawX=199 or 300 -> bg_*.
//  Transparency: rom_q=TRANSP_IDX inside sprite -> bg_*; blank=0 -> 0 regardless.
//  Scale S=1, pos (0,0): DrawX 0,1 -> addr 0; DrawX 2 -> addr 1; DrawY 2 -> addr SPR_W.
//  Loop: start, FRAME_TICKS=2, FRAMES=4 -> anim_frame 0,0,1,1,2,2,3,3,0 over successive fbs.
//  One-shot + stop/start collision: reaches frame 3 -> DONE, anim_done=1, frame held;
//   start&stop same cycle -> IDLE, frame 0.

Source files
------------

// File: rtl/sprite_anim_renderer_if.sv
// Sprite ROM and palette lookup bus: the renderer (master) issues a ROM address and forwards the
// returned palette index; the external sync ROM and combinational palette (slave) answer.
interface sprite_anim_renderer_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_address, pal_index,
        input  rom_q, pal_red, pal_green, pal_blue
    );

    modport slave (
        input  rom_address, pal_index,
        output rom_q, pal_red, pal_green, pal_blue
    );
endinterface

// File: rtl/sprite_anim_renderer.sv
// Draws one animated, positioned, 2^n-scaled sprite over a background colour on the VGA stream,
// with a two-cycle pipeline from DrawX/DrawY to registered RGB and a play/stop/one-shot sequencer.
module sprite_anim_renderer #(
    parameter int SPR_W       = 100,
    parameter int SPR_H       = 100,
    parameter int FRAMES      = 4,
    parameter int IDX_W       = 4,
    parameter int SCALE_SHIFT = 0,
    parameter int FRAME_TICKS = 8,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               vs,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [3:0]         bg_red,
    input  logic [3:0]         bg_green,
    input  logic [3:0]         bg_blue,
    sprite_anim_renderer_if.master bus,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               anim_done
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

    localparam int                 FRAME_SZ   = SPR_W * SPR_H;
    localparam int                 TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [10:0]        SPAN_X     = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0]        SPAN_Y     = 11'(SPR_H << SCALE_SHIFT);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
    localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [IDX_W-1:0]   TRANSP     = IDX_W'(TRANSP_IDX);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               vs_q, vs_d;
    logic               fb;
    logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [10:0]        dx, dy;
    logic               hit;
    logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
    logic               hit1_q, hit1_d, blank1_q, blank1_d;
    logic               hit2_q, hit2_d, blank2_q, blank2_d;
    logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;

    // NOTE: every variable written in an always_comb gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        if (stop) begin
            state_d = IDLE;
            frame_d = '0;
            tick_d  = '0;
        end else if (start) begin
            state_d = PLAY;
            frame_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (fb) begin
                        if (tick_q == LAST_TICK) begin
                            tick_d = '0;
                            if (frame_q == LAST_FRAME) begin
                                if (one_shot) state_d = DONE;
                                else          frame_d = '0;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        vs_d    = vs;
        fb      = vs_q && !vs;
        pos_x_d = fb ? sprite_x : pos_x_q;
        pos_y_d = fb ? sprite_y : pos_y_q;

        // Differences are only meaningful once DrawX/DrawY are known to be at or past the origin.
        dx  = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy  = {1'b0, DrawY} - {1'b0, pos_y_q};
        hit = (DrawX >= pos_x_q) && (dx < SPAN_X) && (DrawY >= pos_y_q) && (dy < SPAN_Y);

        rom_address_d = '0;
        if (hit) begin
            rom_address_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ)
                          + ADDR_W'(dy >> SCALE_SHIFT) * ADDR_W'(SPR_W)
                          + ADDR_W'(dx >> SCALE_SHIFT);
        end
        hit1_d   = hit;
        blank1_d = blank;
        hit2_d   = hit1_q;
        blank2_d = blank1_q;

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (blank2_q) begin
            if (hit2_q && (bus.rom_q != TRANSP)) begin
                red_d   = bus.pal_red;
                green_d = bus.pal_green;
                blue_d  = bus.pal_blue;
            end else begin
                red_d   = bg_red;
                green_d = bg_green;
                blue_d  = bg_blue;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            tick_q        <= '0;
            vs_q          <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            rom_address_q <= '0;
            hit1_q        <= 1'b0;
            blank1_q      <= 1'b0;
            hit2_q        <= 1'b0;
            blank2_q      <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            tick_q        <= tick_d;
            vs_q          <= vs_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            rom_address_q <= rom_address_d;
            hit1_q        <= hit1_d;
            blank1_q      <= blank1_d;
            hit2_q        <= hit2_d;
            blank2_q      <= blank2_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    // The ROM output register is the pipeline stage feeding the combinational palette.
    assign bus.rom_address = rom_address_q;
    assign bus.pal_index   = bus.rom_q;
    assign red             = red_q;
    assign green           = green_q;
    assign blue            = blue_q;
    assign anim_frame      = frame_q;
    assign anim_done       = (state_q == DONE);
endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: two instances (scale 0 and scale 1) share one stimulus stream;
// fixed vectors and sequences cover the corner cases, then a random stream runs against a model.
module tb_sprite_anim_renderer;
    localparam int SPR_W    = 100;
    localparam int SPR_H    = 100;
    localparam int FRAMES   = 4;
    localparam int FT       = 2;
    localparam int IDX_W    = 4;
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int ADDR_W   = $clog2(FRAMES * FRAME_SZ);

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
    logic       blank = 1'b0, vs = 1'b1, start = 1'b0, stop = 1'b0, one_shot = 1'b0;
    logic [3:0] bg_red = 4'hA, bg_green = 4'h3, bg_blue = 4'hC;
    logic [3:0] red0, green0, blue0, red1, green1, blue1;
    logic [1:0] anim_frame0, anim_frame1;
    logic       anim_done0, anim_done1;

    logic [3:0] mem [FRAMES * FRAME_SZ];
    int         n_checks = 0;
    int         n_pass   = 0;

    sprite_anim_renderer_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus0 ();
    sprite_anim_renderer_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus1 ();

    sprite_anim_renderer #(.SCALE_SHIFT(0), .FRAME_TICKS(FT)) dut0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .vs(vs), .sprite_x(sprite_x), .sprite_y(sprite_y), .start(start), .stop(stop),
        .one_shot(one_shot), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .bus(bus0), .red(red0), .green(green0), .blue(blue0),
        .anim_frame(anim_frame0), .anim_done(anim_done0)
    );

    sprite_anim_renderer #(.SCALE_SHIFT(1), .FRAME_TICKS(FT)) dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .vs(vs), .sprite_x(sprite_x), .sprite_y(sprite_y), .start(start), .stop(stop),
        .one_shot(one_shot), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .bus(bus1), .red(red1), .green(green1), .blue(blue1),
        .anim_frame(anim_frame1), .anim_done(anim_done1)
    );

    always #5 vga_clk = ~vga_clk;

    // Sync ROM and combinational palette shared by both instances.
    always @(posedge vga_clk) begin
        bus0.rom_q <= mem[bus0.rom_address];
        bus1.rom_q <= mem[bus1.rom_address];
    end
    assign bus0.pal_red   = bus0.pal_index;
    assign bus0.pal_green = ~bus0.pal_index;
    assign bus0.pal_blue  = bus0.pal_index ^ 4'h5;
    assign bus1.pal_red   = bus1.pal_index;
    assign bus1.pal_green = ~bus1.pal_index;
    assign bus1.pal_blue  = bus1.pal_index ^ 4'h5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic do_fb();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        vs = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int         addr0;
        int         addr1;
        logic [11:0] col0;
        logic [11:0] col1;
    } exp_t;

    exp_t pipe [3];
    bit   m_vs_prev;
    int   m_px, m_py, m_nfb;
    bit   m_active;

    function automatic logic [11:0] pal_rgb(input logic [3:0] idx);
        return {idx, ~idx, idx ^ 4'h5};
    endfunction

    // Frame shown after n frame boundaries of play: each frame lasts FT boundaries.
    function automatic int m_frame();
        int k;
        if (!m_active) return 0;
        k = m_nfb / FT;
        if (k < FRAMES) return k;
        return one_shot ? FRAMES - 1 : k % FRAMES;
    endfunction

    function automatic int m_done();
        return (m_active && one_shot && (m_nfb / FT >= FRAMES)) ? 1 : 0;
    endfunction

    task automatic model_pixel(input int s, output int addr, output logic [11:0] col);
        int dx, dy, scale;
        scale = 1 << s;
        dx = int'(DrawX) - m_px;
        dy = int'(DrawY) - m_py;
        addr = 0;
        col  = blank ? {bg_red, bg_green, bg_blue} : 12'h000;
        if (dx >= 0 && dx < SPR_W * scale && dy >= 0 && dy < SPR_H * scale) begin
            addr = m_frame() * FRAME_SZ + (dy / scale) * SPR_W + dx / scale;
            if (blank && mem[addr] != 4'd0) col = pal_rgb(mem[addr]);
        end
    endtask

    task automatic model_reset();
        m_vs_prev = 1'b0;
        m_px      = 0;
        m_py      = 0;
        m_nfb     = 0;
        m_active  = 1'b0;
        foreach (pipe[i]) pipe[i] = '{0, 0, 12'h000, 12'h000};
    endtask

    task automatic step();
        exp_t e;
        bit   fb;
        model_pixel(0, e.addr0, e.col0);
        model_pixel(1, e.addr1, e.col1);
        fb = m_vs_prev && !vs;
        if (fb) begin
            m_px = int'(sprite_x);
            m_py = int'(sprite_y);
        end
        m_vs_prev = vs;
        if (stop) begin
            m_active = 1'b0;
            m_nfb    = 0;
        end else if (start) begin
            m_active = 1'b1;
            m_nfb    = 0;
        end else if (m_active && fb) begin
            m_nfb++;
        end
        tick();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        check("rnd_addr0", bus0.rom_address, pipe[0].addr0);
        check("rnd_addr1", bus1.rom_address, pipe[0].addr1);
        check("rnd_col0", {red0, green0, blue0}, pipe[2].col0);
        check("rnd_col1", {red1, green1, blue1}, pipe[2].col1);
        check("rnd_frame0", anim_frame0, m_frame());
        check("rnd_frame1", anim_frame1, m_frame());
        check("rnd_done0", anim_done0, m_done());
        check("rnd_done1", anim_done1, m_done());
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        int          addr0;
        int          addr1;
        logic [11:0] col0;
    } vec_t;

    vec_t tbl [8];
    int   exp_loop [8];

    task automatic addr1_at(input int x, input int y, input int exp, input string name);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        check(name, bus1.rom_address, exp);
    endtask

    initial begin
        for (int i = 0; i < FRAMES * FRAME_SZ; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0]    = 4'h5;
        mem[1]    = 4'h0;
        mem[100]  = 4'h9;
        mem[9999] = 4'h3;

        // Sprite at (200,100), frame 0; second column is the scale-1 instance's address.
        tbl[0] = '{10'd200, 10'd100, 1'b1, 0,    0,    12'h5A0};
        tbl[1] = '{10'd201, 10'd100, 1'b1, 1,    0,    12'hA3C};
        tbl[2] = '{10'd200, 10'd101, 1'b1, 100,  0,    12'h96C};
        tbl[3] = '{10'd199, 10'd100, 1'b1, 0,    0,    12'hA3C};
        tbl[4] = '{10'd300, 10'd100, 1'b1, 0,    50,   12'hA3C};
        tbl[5] = '{10'd299, 10'd199, 1'b1, 9999, 4949, 12'h3C6};
        tbl[6] = '{10'd200, 10'd100, 1'b0, 0,    0,    12'h000};
        tbl[7] = '{10'd250, 10'd200, 1'b1, 0,    5025, 12'hA3C};
        exp_loop = '{0, 1, 1, 2, 2, 3, 3, 0};

        // Reset state.
        @(negedge vga_clk);
        @(negedge vga_clk);
        check("rst_rgb", {red0, green0, blue0}, 12'h000);
        check("rst_frame", anim_frame0, 0);
        check("rst_done", anim_done0, 0);
        check("rst_addr", bus0.rom_address, 0);
        reset_n = 1'b1;
        tick();

        // Position, transparency and blanking.
        sprite_x = 10'd200;
        sprite_y = 10'd100;
        do_fb();
        for (int i = 0; i < 8; i++) begin
            DrawX = tbl[i].x;
            DrawY = tbl[i].y;
            blank = tbl[i].b;
            tick();
            check($sformatf("tbl%0d_addr0", i), bus0.rom_address, tbl[i].addr0);
            check($sformatf("tbl%0d_addr1", i), bus1.rom_address, tbl[i].addr1);
            tick();
            tick();
            check($sformatf("tbl%0d_col0", i), {red0, green0, blue0}, tbl[i].col0);
        end

        // Scale 1 at the origin.
        sprite_x = 10'd0;
        sprite_y = 10'd0;
        do_fb();
        addr1_at(0, 0, 0, "scale_x0");
        addr1_at(1, 0, 0, "scale_x1");
        addr1_at(2, 0, 1, "scale_x2");
        addr1_at(0, 2, SPR_W, "scale_y2");

        // Looping animation.
        one_shot = 1'b0;
        pulse_start();
        check("loop_start", anim_frame0, 0);
        for (int i = 0; i < 8; i++) begin
            do_fb();
            check($sformatf("loop_fb%0d", i + 1), anim_frame0, exp_loop[i]);
        end
        do_fb();
        do_fb();
        do_fb();
        check("loop_fb11", anim_frame0, 1);
        pulse_start();
        check("restart_frame", anim_frame0, 0);
        do_fb();
        check("restart_fb1", anim_frame0, 0);
        do_fb();
        check("restart_fb2", anim_frame0, 1);

        // One-shot, then start/stop collision.
        one_shot = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) do_fb();
        check("oneshot_frame", anim_frame0, 3);
        check("oneshot_done", anim_done0, 1);
        do_fb();
        do_fb();
        check("oneshot_hold", anim_frame0, 3);
        check("oneshot_hold_done", anim_done1, 1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("collide_frame", anim_frame0, 0);
        check("collide_done", anim_done0, 0);
        do_fb();
        do_fb();
        check("collide_idle", anim_frame0, 0);

        // Asynchronous reset mid-line while DONE and drawing.
        pulse_start();
        for (int i = 0; i < 8; i++) do_fb();
        DrawX = 10'd5;
        DrawY = 10'd5;
        blank = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_done", anim_done0, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rgb0", {red0, green0, blue0}, 12'h000);
        check("async_rgb1", {red1, green1, blue1}, 12'h000);
        check("async_frame", anim_frame0, 0);
        check("async_done", anim_done0, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Random stream against the model.
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            int t;
            if ($urandom_range(0, 1) == 0) begin
                t = m_px + int'($urandom_range(0, 220)) - 10;
                DrawX = 10'((t < 0) ? 0 : t);
                t = m_py + int'($urandom_range(0, 220)) - 10;
                DrawY = 10'((t < 0) ? 0 : t);
            end else begin
                DrawX = 10'($urandom_range(0, 639));
                DrawY = 10'($urandom_range(0, 479));
            end
            blank = ($urandom_range(0, 7) != 0);
            vs    = ($urandom_range(0, 11) != 0);
            start = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            if (!m_active && $urandom_range(0, 3) == 0) one_shot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                sprite_x = 10'($urandom_range(0, 600));
                sprite_y = 10'($urandom_range(0, 450));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
